hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage RISC-V core. It replaces the single-cycle load-use comparator with a per-register latency scoreboard, so it supports loads and long-latency (mul/div) results of configurable latency. It also handles EX-stage redirect flushes, data-memory wait freezes and a saturating stall-cycle performance counter. It sits beside the ID stage and drives the enables and flushes of the PC, IF/ID and ID/EX registers.

## Interface
- `NUM_REGS`, 32: architectural register count; register 0 is hardwired zero.
- `REG_AW`, 5: register address width, equal to clog2(`NUM_REGS`).
- `LOAD_LAT`, 1: cycles a load result is unavailable to a dependent instruction in ID after the load issues; 1 gives the classic one-bubble load-use stall.
- `LONG_LAT`, 4: same measure for long-latency mul/div results; must be ≥1.
- `PERF_W`, 32: stall counter width.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `id_valid` input 1: the IF/ID register holds a real instruction.
- `id_rs1`, `id_rs2` input `REG_AW`: source register fields of the instruction in ID.
- `id_rs1_used`, `id_rs2_used` input 1: the instruction actually reads that source.
- `id_rd` input `REG_AW`: destination register of the instruction in ID.
- `id_rd_we` input 1: the instruction writes `id_rd`.
- `id_is_load` input 1: the instruction in ID is a load.
- `id_is_long` input 1: the instruction in ID is mul/div; mutually exclusive with `id_is_load`.
- `ex_redirect` input 1: a taken branch or jump resolved in EX.
- `dmem_wait` input 1: data memory not ready; the whole pipeline freezes.
- `pc_en` output 1: PC register write enable.
- `ifid_en` output 1: IF/ID register write enable.
- `ifid_flush` output 1: clear IF/ID to a bubble.
- `idex_en` output 1: ID/EX register write enable.
- `idex_flush` output 1: insert a bubble into ID/EX.
- `stall` output 1: data or structural hazard stall this cycle.
- `perf_stall_cycles` output `PERF_W`: saturating count of cycles with `stall`=1.

## Operation
Scoreboard:
- One down-counter `cnt[r]` per register, width clog2(max(`LOAD_LAT`,`LONG_LAT`)+1).
- Register 0 never has a counter; it is always 0.
- `issue` = `id_valid` & !`stall` & !`ex_redirect` & !`dmem_wait`.

Hazard conditions:
- `raw1` = `id_rs1_used` & `id_rs1`≠0 & `cnt[id_rs1]`≠0. `raw2` is the same for rs2.
- `long_busy` = any long op still counting. An internal `long_cnt` is loaded with `LONG_LAT` on a long issue and decrements.
- `stall` = `id_valid` & !`ex_redirect` & !`dmem_wait` & (`raw1` | `raw2` | (`id_is_long` & `long_busy`)).

Output priority, first match wins:
- **dmem_wait**: `pc_en`=`ifid_en`=`idex_en`=0, no flushes, counters hold, perf counter holds.
- **ex_redirect**: `pc_en`=`ifid_en`=`idex_en`=1, `ifid_flush`=`idex_flush`=1.
- **stall**: `pc_en`=`ifid_en`=0, `idex_en`=1, `idex_flush`=1.
- **otherwise**: `pc_en`=`ifid_en`=`idex_en`=1, no flushes.

Scoreboard update, only when !`dmem_wait`:
- Every nonzero counter decrements by 1.
- On `issue` with `id_rd_we` & `id_rd`≠0, `cnt[id_rd]` is set to `LOAD_LAT` if a load, `LONG_LAT` if long, else 0. The set overrides the decrement of the same entry.
- A write-after-write to the same register replaces the counter with the newer value.

Perf counter: increments on each `stall` cycle and saturates at all-ones.

## Timing
- All outputs are combinational from the inputs and registered state. Every registered element updates on the `clk` rising edge.
- A scoreboard set is visible to the instruction in ID on the cycle after issue.
- With `LOAD_LAT`=L, a dependent instruction directly behind a load stalls exactly L cycles. An independent instruction between them reduces the stall by 1 per intervening cycle.
- `ex_redirect` together with a stall condition: the redirect wins, no stall is counted, and the flushed ID instruction never marks the scoreboard.
- `dmem_wait` together with `ex_redirect`: freeze. The redirect is acted on in the first cycle `dmem_wait` is low.
- `rst_n` low, at any time and including mid-stall: all counters, `long_cnt` and `perf_stall_cycles` clear to 0 immediately.
  - The outputs then evaluate as if the scoreboard were empty: with !`dmem_wait` and !`ex_redirect`, `pc_en`=`ifid_en`=`idex_en`=1, flushes=0, `stall`=0.
- A register-0 source or destination never stalls and never marks.

## Structure
- Package `hazard_pkg` holds:
  - The `op_kind_t` enum (`OP_ALU`, `OP_LOAD`, `OP_LONG`).
  - A function returning the counter width from `LOAD_LAT`/`LONG_LAT`.
  - The default latency constants.
- One sub-module, `hazard_scoreboard`, contains the counter array, set/decrement logic and the two read ports returning `busy1`/`busy2`.
- The top level contains the priority logic, `long_cnt` and the perf counter.

## Test plan
- `LOAD_LAT`=1: `lw x5` issues, then `add x6,x5,x1` is in ID. Expect `stall`=1 for 1 cycle (`pc_en`=0, `idex_flush`=1), then issue. `perf_stall_cycles`=1.
- `LOAD_LAT`=3: load to x7, one independent instruction, then a consumer of x7. Expect 2 stall cycles. A consumer reading x0 after a load to x0 gets 0 stalls.
- `LONG_LAT`=4: `mul x8`, then an immediately following `div x9` (independent). Expect 4 stall cycles on the structural hazard. A consumer of x8 directly behind the mul also gets 4 stalls.
- Load-use stall active while `ex_redirect`=1. Expect `ifid_flush`=`idex_flush`=1, `pc_en`=1, `stall`=0, and x-register counter unchanged by the flushed instruction.
- `dmem_wait`=1 for 3 cycles mid load-use stall. Expect all enables 0, counters frozen; the stall resumes with the same remaining count once wait drops.
- Assert `rst_n`=0 asynchronously with `cnt[x5]`=2 and `perf_stall_cycles`=0xFFFFFFFF. Expect all counters 0 immediately and outputs in the unstalled pattern. Separately, preload the counter to all-ones and stall again: the counter holds at saturation.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        OP_ALU  = 2'd0,
        OP_LOAD = 2'd1,
        OP_LONG = 2'd2
    } op_kind_t;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_REG_AW   = 5;
    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_LONG_LAT = 4;
    localparam int DEF_PERF_W   = 32;

    // Width needed to hold the largest latency value.
    function automatic int cnt_width(input int load_lat, input int long_lat);
        int m;
        m = (load_lat > long_lat) ? load_lat : long_lat;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Handshake between the ID stage and the hazard controller.
interface hazard_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_rd_we;
    logic              id_is_load;
    logic              id_is_long;
    logic              ex_redirect;
    logic              dmem_wait;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_en;
    logic              idex_flush;
    logic              stall;
    logic [PERF_W-1:0] perf_stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load, id_is_long,
               ex_redirect, dmem_wait,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               stall, perf_stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load, id_is_long,
               ex_redirect, dmem_wait,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               stall, perf_stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register result-latency scoreboard: one down-counter per architectural
// register, with a set port for the issuing instruction and two busy read ports.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int LONG_LAT = DEF_LONG_LAT,
    parameter int CW       = cnt_width(DEF_LOAD_LAT, DEF_LONG_LAT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  op_kind_t          set_kind,
    input  logic [REG_AW-1:0] rd1_addr,
    input  logic [REG_AW-1:0] rd2_addr,
    output logic              busy1,
    output logic              busy2
);

    logic [CW-1:0] cnt [NUM_REGS];
    logic [CW-1:0] set_val;

    function automatic logic [CW-1:0] kind_lat(input op_kind_t k);
        case (k)
            OP_LOAD: return CW'(LOAD_LAT);
            OP_LONG: return CW'(LONG_LAT);
            default: return '0;
        endcase
    endfunction

    assign set_val = kind_lat(set_kind);

    // A fresh set overrides the decrement, so a newer writer replaces an older one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else if (!hold) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == 0) begin
                    cnt[i] <= '0;
                end else if (set_en && (set_rd == REG_AW'(i))) begin
                    cnt[i] <= set_val;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    assign busy1 = (rd1_addr != '0) && (cnt[rd1_addr] != '0);
    assign busy2 = (rd2_addr != '0) && (cnt[rd2_addr] != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load/long-latency RAW stalls, mul/div structural
// stall, EX redirect flushes, data-memory freeze and a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int LONG_LAT = DEF_LONG_LAT,
    parameter int PERF_W   = DEF_PERF_W
) (
    input logic     clk,
    input logic     rst_n,
    hazard_if.slave hif
);

    localparam int CW = cnt_width(LOAD_LAT, LONG_LAT);

    op_kind_t          id_kind;
    logic              busy1;
    logic              busy2;
    logic              raw1;
    logic              raw2;
    logic              long_busy;
    logic              live;
    logic              stall;
    logic              issue;
    logic              mark;
    logic [CW-1:0]     long_cnt;
    logic [PERF_W-1:0] perf_cnt;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        if (v == '1) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    always_comb begin
        id_kind = OP_ALU;
        if (hif.id_is_load) begin
            id_kind = OP_LOAD;
        end else if (hif.id_is_long) begin
            id_kind = OP_LONG;
        end
    end

    // An instruction that is redirected away or frozen can neither stall nor issue.
    assign live      = hif.id_valid && !hif.ex_redirect && !hif.dmem_wait;
    assign raw1      = hif.id_rs1_used && busy1;
    assign raw2      = hif.id_rs2_used && busy2;
    assign long_busy = (long_cnt != '0);
    assign stall     = live && (raw1 || raw2 || (hif.id_is_long && long_busy));
    assign issue     = live && !stall;
    assign mark      = issue && hif.id_rd_we && (hif.id_rd != '0);

    hazard_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT),
        .LONG_LAT (LONG_LAT),
        .CW       (CW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hif.dmem_wait),
        .set_en   (mark),
        .set_rd   (hif.id_rd),
        .set_kind (id_kind),
        .rd1_addr (hif.id_rs1),
        .rd2_addr (hif.id_rs2),
        .busy1    (busy1),
        .busy2    (busy2)
    );

    // Tracks the single mul/div unit; a new long op waits until it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt <= '0;
        end else if (!hif.dmem_wait) begin
            if (issue && hif.id_is_long) begin
                long_cnt <= CW'(LONG_LAT);
            end else if (long_cnt != '0) begin
                long_cnt <= long_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else if (stall) begin
            perf_cnt <= sat_inc(perf_cnt);
        end
    end

    // Freeze beats redirect beats stall.
    always_comb begin
        hif.pc_en      = 1'b1;
        hif.ifid_en    = 1'b1;
        hif.ifid_flush = 1'b0;
        hif.idex_en    = 1'b1;
        hif.idex_flush = 1'b0;
        if (hif.dmem_wait) begin
            hif.pc_en   = 1'b0;
            hif.ifid_en = 1'b0;
            hif.idex_en = 1'b0;
        end else if (hif.ex_redirect) begin
            hif.ifid_flush = 1'b1;
            hif.idex_flush = 1'b1;
        end else if (stall) begin
            hif.pc_en      = 1'b0;
            hif.ifid_en    = 1'b0;
            hif.idex_flush = 1'b1;
        end
    end

    assign hif.stall             = stall;
    assign hif.perf_stall_cycles = perf_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two configurations driven with the same
// directed and random instruction stream, checked against a time-based model.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       lg;
        logic       redir;
        logic       wt;
    } in_t;

    typedef struct packed {
        logic [5:0]  ctl;
        logic [63:0] perf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    in_t  cur;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic smp_a;
    logic smp_b;

    // Model state: a register is busy while the effective (non-frozen) cycle
    // count is below the cycle at which its result becomes readable.
    longint rdy  [2][32];
    longint lrdy [2];
    longint eff  [2];
    longint perf [2];

    always #5 clk = ~clk;

    hazard_if #(.REG_AW(5), .PERF_W(32)) hif_a ();
    hazard_if #(.REG_AW(5), .PERF_W(4))  hif_b ();

    hazard_ctrl #(.NUM_REGS(32), .REG_AW(5), .LOAD_LAT(1), .LONG_LAT(4), .PERF_W(32))
        dut_a (.clk(clk), .rst_n(rst_n), .hif(hif_a));
    hazard_ctrl #(.NUM_REGS(32), .REG_AW(5), .LOAD_LAT(3), .LONG_LAT(2), .PERF_W(4))
        dut_b (.clk(clk), .rst_n(rst_n), .hif(hif_b));

    assign hif_a.id_valid    = cur.valid;
    assign hif_a.id_rs1      = cur.rs1;
    assign hif_a.id_rs2      = cur.rs2;
    assign hif_a.id_rs1_used = cur.u1;
    assign hif_a.id_rs2_used = cur.u2;
    assign hif_a.id_rd       = cur.rd;
    assign hif_a.id_rd_we    = cur.we;
    assign hif_a.id_is_load  = cur.ld;
    assign hif_a.id_is_long  = cur.lg;
    assign hif_a.ex_redirect = cur.redir;
    assign hif_a.dmem_wait   = cur.wt;
    assign hif_b.id_valid    = cur.valid;
    assign hif_b.id_rs1      = cur.rs1;
    assign hif_b.id_rs2      = cur.rs2;
    assign hif_b.id_rs1_used = cur.u1;
    assign hif_b.id_rs2_used = cur.u2;
    assign hif_b.id_rd       = cur.rd;
    assign hif_b.id_rd_we    = cur.we;
    assign hif_b.id_is_load  = cur.ld;
    assign hif_b.id_is_long  = cur.lg;
    assign hif_b.ex_redirect = cur.redir;
    assign hif_b.dmem_wait   = cur.wt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint load_lat(input int k);
        return (k == 0) ? 64'sd1 : 64'sd3;
    endfunction

    function automatic longint long_lat(input int k);
        return (k == 0) ? 64'sd4 : 64'sd2;
    endfunction

    function automatic longint perf_max(input int k);
        return (k == 0) ? 64'sd4294967295 : 64'sd15;
    endfunction

    function automatic bit m_busy(input int k, input logic [4:0] r);
        return (r != 5'd0) && (eff[k] < rdy[k][r]);
    endfunction

    function automatic bit m_stall(input int k, input in_t s);
        if (!s.valid || s.redir || s.wt) return 1'b0;
        return (s.u1 && m_busy(k, s.rs1)) || (s.u2 && m_busy(k, s.rs2)) ||
               (s.lg && (eff[k] < lrdy[k]));
    endfunction

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, stall}
    function automatic logic [5:0] m_ctl(input int k, input in_t s);
        if (s.wt)          return 6'b000000;
        if (s.redir)       return 6'b111110;
        if (m_stall(k, s)) return 6'b000111;
        return 6'b110100;
    endfunction

    task automatic m_step(input int k, input in_t s);
        bit st;
        st = m_stall(k, s);
        if (s.wt) return;
        if (st && perf[k] < perf_max(k)) perf[k] = perf[k] + 1;
        if (s.valid && !st && !s.redir) begin
            if (s.we && s.rd != 5'd0)
                rdy[k][s.rd] = eff[k] + 1 + (s.ld ? load_lat(k) : (s.lg ? long_lat(k) : 0));
            if (s.lg) lrdy[k] = eff[k] + 1 + long_lat(k);
        end
        eff[k] = eff[k] + 1;
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            eff[k]  = 0;
            lrdy[k] = 0;
            perf[k] = 0;
            for (int r = 0; r < 32; r++) rdy[k][r] = 0;
        end
    endtask

    task automatic push(input in_t s);
        exp_t e;
        e.ctl  = m_ctl(0, s);
        e.perf = 64'(perf[0]);
        q_a.push_back(e);
        e.ctl  = m_ctl(1, s);
        e.perf = 64'(perf[1]);
        q_b.push_back(e);
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cycle(input in_t s);
        cur = s;
        if (!rst_n) m_reset();
        push(s);
        #3;
        smp_a = hif_a.stall;
        smp_b = hif_b.stall;
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_step(0, s);
            m_step(1, s);
        end
    endtask

    // Counts stall cycles until each configuration first lets the instruction go.
    task automatic run(input in_t s, input int n, output int sa, output int sb);
        bit da;
        bit db;
        da = 1'b0;
        db = 1'b0;
        sa = 0;
        sb = 0;
        for (int i = 0; i < n; i++) begin
            cycle(s);
            if (!da) begin
                if (smp_a) sa++;
                else if (!s.wt) da = 1'b1;
            end
            if (!db) begin
                if (smp_b) sb++;
                else if (!s.wt) db = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(in_t'(0));
    endtask

    function automatic in_t ins(input int rd, input int rs1, input bit u1,
                                input int rs2, input bit u2, input bit ld, input bit lg);
        in_t s;
        s       = '0;
        s.valid = 1'b1;
        s.rd    = 5'(rd);
        s.we    = 1'b1;
        s.rs1   = 5'(rs1);
        s.u1    = u1;
        s.rs2   = 5'(rs2);
        s.u2    = u2;
        s.ld    = ld;
        s.lg    = lg;
        return s;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            chk("a_ctl", 64'({hif_a.pc_en, hif_a.ifid_en, hif_a.ifid_flush,
                              hif_a.idex_en, hif_a.idex_flush, hif_a.stall}), 64'(e.ctl));
            chk("a_perf", 64'(hif_a.perf_stall_cycles), e.perf);
        end
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            chk("b_ctl", 64'({hif_b.pc_en, hif_b.ifid_en, hif_b.ifid_flush,
                              hif_b.idex_en, hif_b.idex_flush, hif_b.stall}), 64'(e.ctl));
            chk("b_perf", 64'(hif_b.perf_stall_cycles), e.perf);
        end
    end

    initial begin : stim
        in_t s;
        in_t cons;
        int  sa;
        int  sb;
        int  ta;
        int  tb;
        int  k;
        cur = '0;
        m_reset();
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
        chk("rst_perf_a", 64'(hif_a.perf_stall_cycles), 64'd0);
        chk("rst_stall_b", 64'(smp_b), 64'd0);
        idle(2);

        // Load directly followed by its consumer.
        cycle(ins(5, 0, 0, 0, 0, 1, 0));
        run(ins(6, 5, 1, 1, 1, 0, 0), 6, sa, sb);
        chk("lu_a", 64'(sa), 64'd1);
        chk("lu_b", 64'(sb), 64'd3);
        chk("lu_perf_a", 64'(hif_a.perf_stall_cycles), 64'd1);
        idle(6);

        // One independent instruction between load and consumer.
        cycle(ins(7, 0, 0, 0, 0, 1, 0));
        cycle(ins(11, 12, 1, 13, 1, 0, 0));
        run(ins(14, 7, 1, 0, 0, 0, 0), 6, sa, sb);
        chk("gap_a", 64'(sa), 64'd0);
        chk("gap_b", 64'(sb), 64'd2);
        idle(6);

        // x0 never marks and never stalls.
        cycle(ins(0, 0, 0, 0, 0, 1, 0));
        run(ins(15, 0, 1, 0, 1, 0, 0), 4, sa, sb);
        chk("x0_a", 64'(sa), 64'd0);
        chk("x0_b", 64'(sb), 64'd0);
        idle(6);

        // Back-to-back long ops share one unit.
        cycle(ins(8, 1, 1, 2, 1, 0, 1));
        run(ins(9, 10, 1, 11, 1, 0, 1), 7, sa, sb);
        chk("long_struct_a", 64'(sa), 64'd4);
        chk("long_struct_b", 64'(sb), 64'd2);
        idle(6);

        // Consumer of a long result.
        cycle(ins(8, 1, 1, 2, 1, 0, 1));
        run(ins(12, 8, 1, 0, 0, 0, 0), 7, sa, sb);
        chk("long_raw_a", 64'(sa), 64'd4);
        chk("long_raw_b", 64'(sb), 64'd2);
        idle(6);

        // Redirect over a load-use stall: the flushed load must not mark x10.
        cycle(ins(5, 0, 0, 0, 0, 1, 0));
        s = ins(10, 5, 1, 0, 0, 1, 0);
        s.redir = 1'b1;
        cycle(s);
        chk("redir_stall_a", 64'(smp_a), 64'd0);
        chk("redir_stall_b", 64'(smp_b), 64'd0);
        run(ins(16, 10, 1, 0, 0, 0, 0), 5, sa, sb);
        chk("redir_nomark_a", 64'(sa), 64'd0);
        chk("redir_nomark_b", 64'(sb), 64'd0);
        idle(6);

        // Freeze in the middle of a load-use stall.
        cycle(ins(5, 0, 0, 0, 0, 1, 0));
        cons = ins(6, 5, 1, 0, 0, 0, 0);
        run(cons, 1, sa, sb);
        ta = sa;
        tb = sb;
        s = cons;
        s.wt = 1'b1;
        s.redir = 1'b1;
        run(s, 3, sa, sb);
        ta += sa;
        tb += sb;
        run(cons, 6, sa, sb);
        ta += sa;
        tb += sb;
        chk("wait_a", 64'(ta), 64'd1);
        chk("wait_b", 64'(tb), 64'd3);
        idle(6);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            s       = '0;
            s.valid = ($urandom_range(0, 9) != 0);
            s.rs1   = 5'($urandom_range(0, 7));
            s.rs2   = 5'($urandom_range(0, 7));
            s.u1    = 1'($urandom_range(0, 1));
            s.u2    = 1'($urandom_range(0, 1));
            s.rd    = 5'($urandom_range(0, 7));
            s.we    = ($urandom_range(0, 3) != 0);
            k       = int'($urandom_range(0, 3));
            s.ld    = (k == 0);
            s.lg    = (k == 1);
            s.redir = ($urandom_range(0, 9) == 0);
            s.wt    = ($urandom_range(0, 9) == 0);
            cycle(s);
        end
        idle(6);
        chk("sat_b", 64'(hif_b.perf_stall_cycles), 64'd15);

        // Asynchronous reset with x5 still counting and the counter saturated.
        cycle(ins(5, 0, 0, 0, 0, 1, 0));
        cons = ins(6, 5, 1, 0, 0, 0, 0);
        cycle(cons);
        cur = cons;
        #2;
        chk("pre_rst_stall_b", 64'(hif_b.stall), 64'd1);
        chk("pre_rst_sat_b", 64'(hif_b.perf_stall_cycles), 64'd15);
        rst_n = 1'b0;
        m_reset();
        push(cons);
        #1;
        chk("async_rst_stall_b", 64'(hif_b.stall), 64'd0);
        chk("async_rst_pc_en_b", 64'(hif_b.pc_en), 64'd1);
        chk("async_rst_flush_b", 64'(hif_b.idex_flush), 64'd0);
        chk("async_rst_perf_b", 64'(hif_b.perf_stall_cycles), 64'd0);
        chk("async_rst_perf_a", 64'(hif_a.perf_stall_cycles), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(cons, 3, sa, sb);
        chk("post_rst_a", 64'(sa), 64'd0);
        chk("post_rst_b", 64'(sb), 64'd0);
        idle(2);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
